// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory between the I-cache and D-cache
// miss handlers: block fills as WORDS sequential reads, D-cache writes as one cycle.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic              icache_grant,
  output logic              dcache_grant,
  output logic              icache_data_vld,
  output logic              dcache_data_vld,
  output logic [DATA_W-1:0] fill_data,
  output logic [OFF_W-1:0]  fill_offset,
  output logic              icache_done,
  output logic              dcache_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;       // 1 = D-cache was granted last
  logic [OFF_W:0]    issue_q, issue_d;     // MSB set once all reads are issued
  logic [OFF_W-1:0]  ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] fill_base;

  assign fill_base = {addr_q[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      issue_q <= '0;
      ret_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    issue_d         = issue_q;
    ret_d           = ret_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    icache_grant    = (state_q == I_FILL);
    dcache_grant    = (state_q == D_FILL) || (state_q == D_WRITE);
    icache_data_vld = 1'b0;
    dcache_data_vld = 1'b0;
    fill_data       = '0;
    fill_offset     = '0;
    icache_done     = 1'b0;
    dcache_done     = 1'b0;
    mem_en          = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    case (state_q)
      IDLE: begin
        issue_d = '0;
        ret_d   = '0;
        // On contention the requester that was not served last wins.
        if (icache_req && (!dcache_req || last_q)) begin
          state_d = I_FILL;
          last_d  = 1'b0;
          addr_d  = icache_addr;
        end else if (dcache_req) begin
          state_d = dcache_wr ? D_WRITE : D_FILL;
          last_d  = 1'b1;
          addr_d  = dcache_addr;
          wdata_d = dcache_wdata;
        end
      end

      I_FILL, D_FILL: begin
        if (!issue_q[OFF_W]) begin
          mem_en   = 1'b1;
          mem_addr = fill_base + ADDR_W'({issue_q[OFF_W-1:0], 1'b0});
          issue_d  = issue_q + 1'b1;
        end
        // Returns may overlap the issue phase; they are counted independently.
        if (mem_rvalid) begin
          fill_data   = mem_rdata;
          fill_offset = ret_q;
          ret_d       = ret_q + 1'b1;
          if (state_q == I_FILL) icache_data_vld = 1'b1;
          else                   dcache_data_vld = 1'b1;
          if (ret_q == OFF_W'(WORDS - 1)) begin
            state_d = IDLE;
            if (state_q == I_FILL) icache_done = 1'b1;
            else                   dcache_done = 1'b1;
          end
        end
      end

      D_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        dcache_done = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a latency-programmable memory model plus a
// transaction-level round-robin model that predicts every cycle of each grant.
module tb_mem_arbiter;
  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_req = 1'b0, dcache_req = 1'b0, dcache_wr = 1'b0;
  logic [15:0] icache_addr = '0, dcache_addr = '0, dcache_wdata = '0;
  logic        icache_grant, dcache_grant, icache_data_vld, dcache_data_vld;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_offset;
  logic        icache_done, dcache_done, mem_en, mem_wr, mem_rvalid;

  int          n_chk = 0, n_fail = 0;
  int          lat = 4;
  logic        spur = 1'b0;
  logic [15:0] spur_data = '0;
  bit          last_m = 1'b0;   // model: 1 = D served last

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .icache_grant(icache_grant), .dcache_grant(dcache_grant),
    .icache_data_vld(icache_data_vld), .dcache_data_vld(dcache_data_vld),
    .fill_data(fill_data), .fill_offset(fill_offset),
    .icache_done(icache_done), .dcache_done(dcache_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return 16'((a * 16'd3) ^ 16'h5A5A);
  endfunction

  // Memory: each read returns exactly lat cycles after issue; spur injects stray rvalids.
  logic [7:0]  pv = '0;
  logic [15:0] pa [0:7];
  logic [7:0]  lat_mask;
  assign lat_mask = 8'((9'd1 << lat) - 9'd1);
  always @(posedge clk) begin
    pv    <= {pv[6:0], mem_en && !mem_wr} & lat_mask;
    pa[0] <= mem_addr;
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvalid = pv[lat-1] | spur;
  assign mem_rdata  = pv[lat-1] ? memfn(pa[lat-1]) : spur_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {icache_grant, dcache_grant, icache_data_vld, dcache_data_vld,
                          icache_done, dcache_done, mem_en, mem_wr}, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_fdata"}, fill_data, 0);
    check({tag, "_off"}, fill_offset, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_grant", {icache_grant, dcache_grant}, 0);
      check("idle_memen", mem_en, 0);
      check("idle_vld", {icache_data_vld, dcache_data_vld, icache_done, dcache_done}, 0);
    end
  endtask

  // Follows one transaction whose grant is expected gap cycles from now.
  task automatic serve(input bit own_d, input int gap, input logic [15:0] a,
                       input bit wr, input logic [15:0] wd);
    logic [15:0] base;
    int          span, u;
    base = a & ~16'(2 * WORDS - 1);
    span = wr ? 1 : lat + WORDS;
    for (int t = 1; t < gap + span; t++) begin
      spur      = (t < gap || (wr && t == gap)) ? ($urandom_range(0, 3) == 0) : 1'b0;
      spur_data = 16'($urandom);
      @(negedge clk);
      if (t < gap) begin
        check("gap_grant", {icache_grant, dcache_grant}, 0);
        check("gap_memen", mem_en, 0);
        check("gap_vld", {icache_data_vld, dcache_data_vld, icache_done, dcache_done}, 0);
      end else begin
        u = t - gap;
        check("grant", {icache_grant, dcache_grant}, own_d ? 2'b01 : 2'b10);
        if (wr) begin
          check("wr_en", {mem_en, mem_wr}, 2'b11);
          check("wr_addr", mem_addr, a);
          check("wr_wdata", mem_wdata, wd);
          check("wr_done", {icache_done, dcache_done}, 2'b01);
          check("wr_vld", {icache_data_vld, dcache_data_vld}, 0);
        end else begin
          check("rd_en", {mem_en, mem_wr}, (u < WORDS) ? 2'b10 : 2'b00);
          if (u < WORDS) check("rd_addr", mem_addr, 16'(base + 2 * u));
          check("fill_vld", {icache_data_vld, dcache_data_vld},
                (u >= lat) ? (own_d ? 2'b01 : 2'b10) : 2'b00);
          if (u >= lat) begin
            check("fill_data", fill_data, memfn(16'(base + 2 * (u - lat))));
            check("fill_off", fill_offset, u - lat);
          end
          check("fill_done", {icache_done, dcache_done},
                (u == lat + WORDS - 1) ? (own_d ? 2'b01 : 2'b10) : 2'b00);
        end
        // Owner inputs are not re-sampled after the grant: scramble them.
        if (u == 0) begin
          if (own_d) begin
            dcache_addr  = 16'($urandom);
            dcache_wr    = 1'($urandom);
            dcache_wdata = 16'($urandom);
            if ($urandom_range(0, 1) == 1) dcache_req = 1'b0;
          end else begin
            icache_addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) icache_req = 1'b0;
          end
        end
      end
    end
    spur = 1'b0;
  endtask

  // Raises the requested set and serves it to completion in round-robin order.
  task automatic run_scn(input bit wi, input logic [15:0] ia, input bit wd, input bit dwr,
                         input logic [15:0] da, input logic [15:0] dwd, input bit twice,
                         input int l);
    bit          ip, dp, own;
    int          gap;
    logic [15:0] d_a, d_wd;
    bit          d_w;
    idle_cycles(1);
    lat = l;
    idle_cycles($urandom_range(0, 2));
    ip = wi; dp = wd; d_a = da; d_w = dwr; d_wd = dwd;
    icache_req = wi; icache_addr = ia;
    dcache_req = wd; dcache_wr = dwr; dcache_addr = da; dcache_wdata = dwd;
    gap = 1;
    while (ip || dp) begin
      own = (ip && dp) ? !last_m : dp;
      if (own) serve(1'b1, gap, d_a, d_w, d_wd);
      else     serve(1'b0, gap, ia, 1'b0, 16'h0);
      last_m = own;
      if (!own) begin
        ip = 1'b0; icache_req = 1'b0;
      end else if (twice) begin
        twice = 1'b0;
        d_a = 16'($urandom); d_w = 1'($urandom); d_wd = 16'($urandom);
        dcache_req = 1'b1; dcache_addr = d_a; dcache_wr = d_w; dcache_wdata = d_wd;
      end else begin
        dp = 1'b0; dcache_req = 1'b0;
      end
      gap = 2;
    end
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      icache_req = 1'($urandom); dcache_req = 1'($urandom); dcache_wr = 1'($urandom);
      icache_addr = 16'($urandom); dcache_addr = 16'($urandom);
      dcache_wdata = 16'($urandom); spur = 1'($urandom); spur_data = 16'($urandom);
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    icache_req = 1'b0; dcache_req = 1'b0; spur = 1'b0;
    rst = 1'b0;
    idle_cycles(3);

    // Single I fill at 0x1236 with latency 4.
    run_scn(1'b1, 16'h1236, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4);
    // Simultaneous I and D fill: D first since I went last.
    run_scn(1'b1, 16'h0880, 1'b1, 1'b0, 16'h0400, 16'h0, 1'b0, 3);
    // D re-requests back-to-back while I waits: D, I, D.
    run_scn(1'b1, 16'h3002, 1'b1, 1'b0, 16'h0500, 16'h0, 1'b1, 2);
    // Single-cycle D write, unaligned address kept.
    run_scn(1'b0, 16'h0, 1'b1, 1'b1, 16'h0041, 16'hBEEF, 1'b0, 4);

    for (int n = 0; n < 40; n++) begin
      int m;
      m = $urandom_range(0, 2);
      run_scn(m != 1, 16'($urandom), m != 0, 1'($urandom), 16'($urandom), 16'($urandom),
              (m != 0) && ($urandom_range(0, 3) == 0), $urandom_range(1, 5));
    end

    // Reset mid-fill after three returns have been accepted.
    idle_cycles(1);
    lat = 4;
    icache_req = 1'b1; icache_addr = 16'h2A5C;
    @(negedge clk);
    check("abort_grant", {icache_grant, dcache_grant}, 2'b10);
    repeat (lat + 3) @(negedge clk);
    check("abort_pre_vld", {icache_data_vld, fill_offset}, {1'b1, 3'd3});
    rst = 1'b1;
    icache_req = 1'b0;
    #1;
    check_all_zero("abort_now");
    @(negedge clk);
    check_all_zero("abort_hold");
    rst = 1'b0;
    last_m = 1'b0;
    idle_cycles(12);
    run_scn(1'b1, 16'hFFF8, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
